// File: rtl/lb_cmd_pkg.sv
// Shared widths, command codes and types for the local-bus command sequencer.
package lb_cmd_pkg;

  localparam int unsigned LbCWidth = 8;
  localparam int unsigned LbAWidth = 24;
  localparam int unsigned LbDWidth = 32;

  localparam logic [LbCWidth-1:0] WriteCmd = 8'h01;
  localparam logic [LbCWidth-1:0] ReadCmd  = 8'h10;

  typedef struct packed {
    logic [LbCWidth-1:0] ctrl;
    logic [LbAWidth-1:0] addr;
    logic [LbDWidth-1:0] data;
  } lb_cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} lb_seq_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lb_cmd_seq_if.sv
// Host command stream, local-bus port and read-response stream of lb_cmd_seq.
// rsp_ts is present only when LB_CMD_TIMESTAMP_EN is defined.
interface lb_cmd_seq_if #(
  parameter int unsigned LBCWIDTH = lb_cmd_pkg::LbCWidth,
  parameter int unsigned LBAWIDTH = lb_cmd_pkg::LbAWidth,
  parameter int unsigned LBDWIDTH = lb_cmd_pkg::LbDWidth
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [LBCWIDTH-1:0] cmd_ctrl;
  logic [LBAWIDTH-1:0] cmd_addr;
  logic [LBDWIDTH-1:0] cmd_data;
  logic                lb_wvalid;
  logic [LBCWIDTH-1:0] lb_wctrl;
  logic [LBAWIDTH-1:0] lb_waddr;
  logic [LBDWIDTH-1:0] lb_wdata;
  logic                lb_read;
  logic [LBDWIDTH-1:0] lb_rdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [LBAWIDTH-1:0] rsp_addr;
  logic [LBDWIDTH-1:0] rsp_data;
`ifdef LB_CMD_TIMESTAMP_EN
  logic [31:0]         rsp_ts;

  modport slave (
    input  cmd_valid, cmd_ctrl, cmd_addr, cmd_data, lb_rdata, rsp_ready,
    output cmd_ready, lb_wvalid, lb_wctrl, lb_waddr, lb_wdata, lb_read,
    output rsp_valid, rsp_addr, rsp_data, rsp_ts
  );
  modport master (
    output cmd_valid, cmd_ctrl, cmd_addr, cmd_data, lb_rdata, rsp_ready,
    input  cmd_ready, lb_wvalid, lb_wctrl, lb_waddr, lb_wdata, lb_read,
    input  rsp_valid, rsp_addr, rsp_data, rsp_ts
  );
`else
  modport slave (
    input  cmd_valid, cmd_ctrl, cmd_addr, cmd_data, lb_rdata, rsp_ready,
    output cmd_ready, lb_wvalid, lb_wctrl, lb_waddr, lb_wdata, lb_read,
    output rsp_valid, rsp_addr, rsp_data
  );
  modport master (
    output cmd_valid, cmd_ctrl, cmd_addr, cmd_data, lb_rdata, rsp_ready,
    input  cmd_ready, lb_wvalid, lb_wctrl, lb_waddr, lb_wdata, lb_read,
    input  rsp_valid, rsp_addr, rsp_data
  );
`endif

endinterface

// File: rtl/lb_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags; Depth must be a power of two >= 2.
module lb_cmd_fifo
  import lb_cmd_pkg::*;
#(
  parameter type         entry_t = lb_cmd_t,
  parameter int unsigned Depth   = 16
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  entry_t wdata_i,
  input  logic   pop_i,
  output entry_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [PtrW:0]   CntOne   = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(Depth);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            full_q, empty_q;
  logic            do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  // Flags are derived from next count so they are plain flops at the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DepthCnt);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/lb_cmd_seq.sv
// Local-bus command sequencer: buffers host commands and turns each into one write/read strobe.
// Define LB_CMD_TIMESTAMP_EN to add a free-running cycle counter and the rsp_ts output.
module lb_cmd_seq
  import lb_cmd_pkg::*;
#(
  parameter int unsigned         LBCWIDTH  = LbCWidth,
  parameter int unsigned         LBAWIDTH  = LbAWidth,
  parameter int unsigned         LBDWIDTH  = LbDWidth,
  parameter logic [LBCWIDTH-1:0] WRITECMD  = LBCWIDTH'(WriteCmd),
  parameter logic [LBCWIDTH-1:0] READCMD   = LBCWIDTH'(ReadCmd),
  parameter int unsigned         READLAT   = 4,
  parameter int unsigned         FIFODEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  lb_cmd_seq_if.slave bus,
  output logic [15:0] err_cnt,
  output logic        busy
);

  typedef struct packed {
    logic [LBCWIDTH-1:0] ctrl;
    logic [LBAWIDTH-1:0] addr;
    logic [LBDWIDTH-1:0] data;
  } cmd_t;

  localparam logic [3:0] LatLoad = 4'(READLAT - 1);

  cmd_t                push_cmd, pop_cmd;
  logic                fifo_full, fifo_empty, pop;

  lb_seq_state_t       state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [3:0]          lat_q, lat_d;
  logic [LBDWIDTH-1:0] rdata_q, rdata_d;
  logic [15:0]         err_q, err_d;
  logic                wvalid, read, rsp_valid;

  assign push_cmd = cmd_t'{ctrl: bus.cmd_ctrl, addr: bus.cmd_addr, data: bus.cmd_data};

  lb_cmd_fifo #(
    .entry_t (cmd_t),
    .Depth   (FIFODEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.cmd_valid),
    .wdata_i (push_cmd),
    .pop_i   (pop),
    .rdata_o (pop_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    lat_d     = lat_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    pop       = 1'b0;
    wvalid    = 1'b0;
    read      = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cmd_d   = pop_cmd;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_q.ctrl == WRITECMD) begin
          wvalid  = 1'b1;
          state_d = IDLE;
        end else if (cmd_q.ctrl == READCMD) begin
          read    = 1'b1;
          lat_d   = LatLoad;
          state_d = RWAIT;
        end else begin
          err_d   = sat_inc16(err_q);
          state_d = IDLE;
        end
      end
      RWAIT: begin
        if (lat_q == 4'd0) begin
          rdata_d = bus.lb_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The command register doubles as the write-address/data and response-address holder.
  assign bus.cmd_ready = ~fifo_full;
  assign bus.lb_wvalid = wvalid;
  assign bus.lb_wctrl  = cmd_q.ctrl;
  assign bus.lb_waddr  = cmd_q.addr;
  assign bus.lb_wdata  = cmd_q.data;
  assign bus.lb_read   = read;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_addr  = cmd_q.addr;
  assign bus.rsp_data  = rdata_q;
  assign err_cnt       = err_q;
  assign busy          = ~fifo_empty | (state_q != IDLE);

`ifdef LB_CMD_TIMESTAMP_EN
  logic [31:0] ts_q, rsp_ts_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q     <= '0;
      rsp_ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (read) rsp_ts_q <= ts_q;
    end
  end

  assign bus.rsp_ts = rsp_ts_q;
`endif

endmodule

// File: tb/tb_lb_cmd_seq.sv
// Self-checking bench for lb_cmd_seq: directed scenarios plus a randomized run against a
// transaction-level model (ordered writes, ordered read responses, error count).
module tb_lb_cmd_seq;
  import lb_cmd_pkg::*;

  localparam int unsigned READLAT = 4;
  localparam int unsigned DEPTH   = 16;
  localparam logic [7:0]  WR      = 8'h01;
  localparam logic [7:0]  RD      = 8'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] err_cnt;
  logic        busy;

  lb_cmd_seq_if bus ();

  lb_cmd_seq #(
    .READLAT   (READLAT),
    .FIFODEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  c;
    logic [23:0] a;
    logic [31:0] d;
  } wr_ev_t;

  typedef struct {
    int          cyc;
    logic [23:0] a;
    logic [31:0] d;
    logic        hs;
  } rsp_ev_t;

  int          push_log[$];
  wr_ev_t      wr_log[$];
  wr_ev_t      rd_log[$];
  rsp_ev_t     rsp_log[$];
  int          rd_cyc  = -1000;
  logic [23:0] rd_addr = '0;
  int          checks  = 0;
  int          errors  = 0;
  int          err_exp = 0;

  // Register-map model: data is valid on lb_rdata only in the cycle READLAT after lb_read.
  function automatic logic [31:0] rd_model(input logic [23:0] a);
    if (a == 24'h000020) return 32'h12345678;
    return {a[7:0], a} ^ 32'h5A5A_C3C3;
  endfunction

  always @(negedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) push_log.push_back(cyc);
    if (bus.lb_wvalid) wr_log.push_back('{cyc, bus.lb_wctrl, bus.lb_waddr, bus.lb_wdata});
    if (bus.lb_read) begin
      rd_log.push_back('{cyc, 8'h00, bus.lb_waddr, 32'h0});
      rd_cyc  = cyc;
      rd_addr = bus.lb_waddr;
    end
    if (bus.rsp_valid) rsp_log.push_back('{cyc, bus.rsp_addr, bus.rsp_data, bus.rsp_ready});
    bus.lb_rdata = (cyc == rd_cyc + int'(READLAT)) ? rd_model(rd_addr) : $urandom;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    push_log.delete();
    wr_log.delete();
    rd_log.delete();
    rsp_log.delete();
  endtask

  task automatic push(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_ctrl  = c;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    @(negedge clk);
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL push_timeout cmd_ready=%b waited=%0d required<300", bus.cmd_ready, n);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clk);
    while ((busy || bus.rsp_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 400) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%b required=0", tag, busy);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int hs_cycle();
    foreach (rsp_log[i]) if (rsp_log[i].hs) return rsp_log[i].cyc;
    return -1;
  endfunction

  task automatic check_reset_values(input string tag);
    checks++;
    if ({bus.cmd_ready, bus.lb_wvalid, bus.lb_read, bus.rsp_valid, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL %s_flags got=%b required=10000 (ready,wvalid,read,rsp_valid,busy)", tag,
               {bus.cmd_ready, bus.lb_wvalid, bus.lb_read, bus.rsp_valid, busy});
    end
    checks++;
    if ({bus.lb_wctrl, bus.lb_waddr, bus.lb_wdata, bus.rsp_addr, bus.rsp_data} !== '0) begin
      errors++;
      $display("FAIL %s_buses wctrl=%h waddr=%h wdata=%h raddr=%h rdata=%h required=0", tag,
               bus.lb_wctrl, bus.lb_waddr, bus.lb_wdata, bus.rsp_addr, bus.rsp_data);
    end
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s_err_cnt got=%0d required=0", tag, err_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_ctrl  = '0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    step(3);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(2);
    @(negedge clk);
    check_reset_values("post_reset");
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_write();
    clear_logs();
    bus.rsp_ready = 1'b1;
    push(WR, 24'h000010, 32'hDEADBEEF);
    step(8);
    checks++;
    if (wr_log.size() != 1 || push_log.size() != 1) begin
      errors++;
      $display("FAIL write_count strobes=%0d pushes=%0d required=1/1", wr_log.size(),
               push_log.size());
    end else begin
      checks++;
      if (wr_log[0].cyc - push_log[0] != 2) begin
        errors++;
        $display("FAIL write_latency got=%0d required=2", wr_log[0].cyc - push_log[0]);
      end
      checks++;
      if ({wr_log[0].c, wr_log[0].a, wr_log[0].d} !== {WR, 24'h000010, 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL write_values got=%h/%h/%h required=01/000010/deadbeef", wr_log[0].c,
                 wr_log[0].a, wr_log[0].d);
      end
    end
    checks++;
    if (rsp_log.size() != 0 || rd_log.size() != 0) begin
      errors++;
      $display("FAIL write_no_rsp rsp=%0d reads=%0d required=0/0", rsp_log.size(),
               rd_log.size());
    end
  endtask

  task automatic test_read();
    clear_logs();
    bus.rsp_ready = 1'b1;
    push(RD, 24'h000020, 32'hFFFF_FFFF);
    wait_idle("read");
    checks++;
    if (rd_log.size() != 1 || rsp_log.size() != 1) begin
      errors++;
      $display("FAIL read_count reads=%0d rsp_cycles=%0d required=1/1", rd_log.size(),
               rsp_log.size());
    end else begin
      checks++;
      if (rd_log[0].cyc - push_log[0] != 2) begin
        errors++;
        $display("FAIL read_strobe_latency got=%0d required=2", rd_log[0].cyc - push_log[0]);
      end
      checks++;
      if (rsp_log[0].cyc - rd_log[0].cyc != int'(READLAT) + 1) begin
        errors++;
        $display("FAIL read_rsp_latency got=%0d required=%0d", rsp_log[0].cyc - rd_log[0].cyc,
                 READLAT + 1);
      end
      checks++;
      if ({rsp_log[0].a, rsp_log[0].d, wr_log.size() == 0} !== {24'h000020, 32'h12345678, 1'b1})
      begin
        errors++;
        $display("FAIL read_rsp_values addr=%h data=%h writes=%0d required=000020/12345678/0",
                 rsp_log[0].a, rsp_log[0].d, wr_log.size());
      end
    end
  endtask

  task automatic test_bad_ctrl();
    clear_logs();
    bus.rsp_ready = 1'b1;
    push(8'h55, 24'h0000AA, 32'h0BAD_0BAD);
    push(WR, 24'h000044, 32'hCAFE_F00D);
    wait_idle("bad_ctrl");
    err_exp++;
    checks++;
    if (err_cnt !== 16'(err_exp)) begin
      errors++;
      $display("FAIL bad_ctrl_err_cnt got=%0d required=%0d", err_cnt, err_exp);
    end
    checks++;
    if (wr_log.size() != 1 || rd_log.size() != 0 || rsp_log.size() != 0) begin
      errors++;
      $display("FAIL bad_ctrl_strobes writes=%0d reads=%0d rsp=%0d required=1/0/0",
               wr_log.size(), rd_log.size(), rsp_log.size());
    end else begin
      checks++;
      if ({wr_log[0].a, wr_log[0].d, wr_log[0].cyc - push_log[0]} !==
          {24'h000044, 32'hCAFE_F00D, 32'd4}) begin
        errors++;
        $display("FAIL bad_ctrl_write addr=%h data=%h latency=%0d required=000044/cafef00d/4",
                 wr_log[0].a, wr_log[0].d, wr_log[0].cyc - push_log[0]);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [23:0] wa[20];
    logic [31:0] wd[20];
    logic [23:0] ra;
    int          hs, bad_gap, bad_val;
    clear_logs();
    bus.rsp_ready = 1'b0;
    ra = 24'($urandom);
    foreach (wa[i]) begin
      wa[i] = 24'($urandom);
      wd[i] = $urandom;
    end
    push(RD, ra, 32'h0);
    for (int i = 0; i < 16; i++) push(WR, wa[i], wd[i]);
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL full_ready got ready=%b busy=%b required=0/1", bus.cmd_ready, busy);
    end
    step(3);
    checks++;
    if (wr_log.size() != 0) begin
      errors++;
      $display("FAIL full_blocked writes=%0d required=0", wr_log.size());
    end
    bus.rsp_ready = 1'b1;
    for (int i = 16; i < 20; i++) push(WR, wa[i], wd[i]);
    wait_idle("full");
    hs = hs_cycle();
    checks++;
    if (push_log.size() != 21 || hs < 0) begin
      errors++;
      $display("FAIL full_pushes pushes=%0d hs=%0d required=21/>=0", push_log.size(), hs);
    end else begin
      checks++;
      if (push_log[17] - hs != 2) begin
        errors++;
        $display("FAIL full_ready_rise got=%0d required=2 cycles after handshake",
                 push_log[17] - hs);
      end
    end
    checks++;
    if (wr_log.size() != 20) begin
      errors++;
      $display("FAIL full_write_count got=%0d required=20", wr_log.size());
    end else begin
      bad_gap = 0;
      bad_val = 0;
      foreach (wr_log[i]) begin
        if ({wr_log[i].c, wr_log[i].a, wr_log[i].d} !== {WR, wa[i], wd[i]}) bad_val++;
        if (i > 0 && wr_log[i].cyc - wr_log[i-1].cyc != 2) bad_gap++;
      end
      checks++;
      if (bad_val != 0) begin
        errors++;
        $display("FAIL full_write_order bad_entries=%0d required=0", bad_val);
      end
      checks++;
      if (bad_gap != 0 || wr_log[0].cyc - hs != 2) begin
        errors++;
        $display("FAIL full_write_spacing bad_gaps=%0d first=%0d required=0/2", bad_gap,
                 wr_log[0].cyc - hs);
      end
    end
    checks++;
    if (rsp_log.size() == 0 || rsp_log[0].a !== ra || rsp_log[0].d !== rd_model(ra)) begin
      errors++;
      $display("FAIL full_read_rsp entries=%0d required>0 with addr=%h data=%h", rsp_log.size(),
               ra, rd_model(ra));
    end
  endtask

  task automatic test_rsp_stall();
    logic [23:0] ra, wa;
    logic [31:0] wd;
    int          k, unstable, hs;
    clear_logs();
    bus.rsp_ready = 1'b0;
    ra = 24'($urandom);
    wa = 24'($urandom);
    wd = $urandom;
    push(RD, ra, 32'h0);
    push(WR, wa, wd);
    k = 0;
    while (rsp_log.size() == 0 && k < 40) begin
      step(1);
      k++;
    end
    step(10);
    checks++;
    if (wr_log.size() != 0) begin
      errors++;
      $display("FAIL stall_write_blocked writes=%0d required=0", wr_log.size());
    end
    bus.rsp_ready = 1'b1;
    wait_idle("stall");
    unstable = 0;
    foreach (rsp_log[i]) if (rsp_log[i].a !== ra || rsp_log[i].d !== rd_model(ra)) unstable++;
    hs = hs_cycle();
    checks++;
    if (rsp_log.size() < 11 || unstable != 0) begin
      errors++;
      $display("FAIL stall_rsp_stable cycles=%0d bad=%0d required>=11/0", rsp_log.size(),
               unstable);
    end
    checks++;
    if (wr_log.size() != 1 || hs < 0) begin
      errors++;
      $display("FAIL stall_write_count got=%0d hs=%0d required=1/>=0", wr_log.size(), hs);
    end else begin
      checks++;
      if ({wr_log[0].a, wr_log[0].d} !== {wa, wd} || wr_log[0].cyc - hs != 2) begin
        errors++;
        $display("FAIL stall_write addr=%h data=%h gap=%0d required=%h/%h/2", wr_log[0].a,
                 wr_log[0].d, wr_log[0].cyc - hs, wa, wd);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [7:0]  cs[N];
    logic [23:0] as[N];
    logic [31:0] ds[N];
    wr_ev_t      exp_wr[$];
    logic [23:0] exp_rd[$];
    rsp_ev_t     got_rsp[$];
    int          idx, r, bad;
    logic        acc;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 9);
      as[i] = 24'($urandom);
      ds[i] = $urandom;
      if (r < 5) cs[i] = WR;
      else if (r < 8) cs[i] = RD;
      else begin
        do cs[i] = 8'($urandom); while (cs[i] == WR || cs[i] == RD);
      end
      if (cs[i] == WR) exp_wr.push_back('{0, WR, as[i], ds[i]});
      else if (cs[i] == RD) exp_rd.push_back(as[i]);
      else err_exp++;
    end
    idx = 0;
    for (int k = 0; k < 4000 && idx < N; k++) begin
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_ctrl  = cs[idx];
      bus.cmd_addr  = as[idx];
      bus.cmd_data  = ds[idx];
      bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle("random");
    checks++;
    if (idx != N) begin
      errors++;
      $display("FAIL random_accepted got=%0d required=%0d", idx, N);
    end
    checks++;
    if (wr_log.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL random_write_count got=%0d required=%0d", wr_log.size(), exp_wr.size());
    end else begin
      bad = 0;
      foreach (exp_wr[i]) if ({wr_log[i].c, wr_log[i].a, wr_log[i].d} !==
                              {exp_wr[i].c, exp_wr[i].a, exp_wr[i].d}) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_write_data bad_entries=%0d required=0", bad);
      end
    end
    foreach (rsp_log[i]) if (rsp_log[i].hs) got_rsp.push_back(rsp_log[i]);
    checks++;
    if (got_rsp.size() != exp_rd.size() || rd_log.size() != exp_rd.size()) begin
      errors++;
      $display("FAIL random_read_count rsp=%0d reads=%0d required=%0d", got_rsp.size(),
               rd_log.size(), exp_rd.size());
    end else begin
      bad = 0;
      foreach (exp_rd[i]) if (got_rsp[i].a !== exp_rd[i] || got_rsp[i].d !== rd_model(exp_rd[i]))
        bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_read_data bad_entries=%0d required=0", bad);
      end
    end
    checks++;
    if (err_cnt !== 16'(err_exp)) begin
      errors++;
      $display("FAIL random_err_cnt got=%0d required=%0d", err_cnt, err_exp);
    end
  endtask

  task automatic test_reset_rwait();
    logic [23:0] ra;
    int          k;
    clear_logs();
    bus.rsp_ready = 1'b1;
    push(RD, 24'h0000C4, 32'h0);
    push(WR, 24'h0000C8, 32'h1111_2222);
    k = 0;
    while (rd_log.size() == 0 && k < 20) begin
      step(1);
      k++;
    end
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    err_exp = 0;
    @(negedge clk);
    checks++;
    if ({busy, bus.rsp_valid, bus.cmd_ready} !== 3'b001 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rwait_reset busy=%b rsp_valid=%b ready=%b err=%0d required=0/0/1/0", busy,
               bus.rsp_valid, bus.cmd_ready, err_cnt);
    end
    step(10);
    checks++;
    if (rsp_log.size() != 0 || wr_log.size() != 0) begin
      errors++;
      $display("FAIL rwait_dropped rsp=%0d writes=%0d required=0/0", rsp_log.size(),
               wr_log.size());
    end
    clear_logs();
    ra = 24'($urandom);
    push(RD, ra, 32'h0);
    wait_idle("rwait_after");
    checks++;
    if (rsp_log.size() != 1 || rd_log.size() != 1) begin
      errors++;
      $display("FAIL rwait_next_count rsp=%0d reads=%0d required=1/1", rsp_log.size(),
               rd_log.size());
    end else begin
      checks++;
      if ({rsp_log[0].a, rsp_log[0].d} !== {ra, rd_model(ra)} ||
          rsp_log[0].cyc - rd_log[0].cyc != int'(READLAT) + 1) begin
        errors++;
        $display("FAIL rwait_next_rsp addr=%h data=%h lat=%0d required=%h/%h/%0d", rsp_log[0].a,
                 rsp_log[0].d, rsp_log[0].cyc - rd_log[0].cyc, ra, rd_model(ra), READLAT + 1);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_bad_ctrl();
    test_fifo_full();
    test_rsp_stall();
    test_random();
    test_reset_rwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lb_cmd_seq.md
# lb_cmd_seq

Local-bus command sequencer that sits directly upstream of the register map and drives its local-bus write/read port. It accepts host command words (ctrl, addr, data) on a valid/ready stream and buffers them in a FIFO. Each command becomes a single-cycle local-bus write or read strobe. Read data is returned on a response stream after a fixed read latency.

## Interface
Parameters:
- LBCWIDTH, 8, control-word width
- LBAWIDTH, 24, address width
- LBDWIDTH, 32, data width
- WRITECMD, 8'h01, ctrl code for a write
- READCMD, 8'h10, ctrl code for a read
- READLAT, 4, cycles from lb_read to valid lb_rdata (1..15)
- FIFODEPTH, 16, command FIFO depth (power of two)

Ports:
- clk  in  1  local-bus clock (one clock; reset is synchronous and active-high)
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command word present
- cmd_ready  out  1  FIFO not full
- cmd_ctrl  in  LBCWIDTH  command code
- cmd_addr  in  LBAWIDTH  target address
- cmd_data  in  LBDWIDTH  write data (ignored for reads)
- lb_wvalid  out  1  one-cycle write strobe
- lb_wctrl  out  LBCWIDTH  ctrl presented with the strobe
- lb_waddr  out  LBAWIDTH  address
- lb_wdata  out  LBDWIDTH  write data
- lb_read  out  1  one-cycle read strobe
- lb_rdata  in  LBDWIDTH  read data from the register map
- rsp_valid  out  1  read response available
- rsp_ready  in  1  response consumer ready
- rsp_addr  out  LBAWIDTH  address of the read
- rsp_data  out  LBDWIDTH  read data
- err_cnt  out  16  count of unknown-ctrl commands, saturating
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- FIFO push on cmd_valid & cmd_ready. cmd_ready = !full; no push is lost.
- FSM states:
  - IDLE: if FIFO non-empty, pop into the command register and go to ISSUE.
  - ISSUE, by ctrl:
    - ctrl==WRITECMD: lb_wvalid=1 and lb_wctrl=WRITECMD for one cycle, then IDLE.
    - ctrl==READCMD: lb_read=1 for one cycle, then RWAIT.
    - any other ctrl: no strobe, err_cnt += 1 (saturates at 16'hFFFF), then IDLE.
  - RWAIT: down-counter loaded with READLAT-1. When it reaches 0, capture lb_rdata and go to RESP.
  - RESP: rsp_valid=1 with rsp_addr/rsp_data held stable until rsp_ready. Return to IDLE on the handshake.
- lb_waddr/lb_wdata/lb_wctrl hold the last issued command between strobes. They are don't-care to the consumer when no strobe is high.
- Reads are strictly ordered; at most one read is outstanding. A blocked response stalls all later commands, including writes.

## Timing
- Reset values: cmd_ready=1 (FIFO cleared), lb_wvalid=0, lb_read=0, lb_wctrl/lb_waddr/lb_wdata=0, rsp_valid=0, rsp_addr/rsp_data=0, err_cnt=0, busy=0, FSM=IDLE.
- Empty-FIFO push at cycle t: pop in IDLE at t+1, strobe at t+2.
- Back-to-back writes: one strobe every 2 cycles.
- lb_read high in cycle t: lb_rdata sampled at the end of cycle t+READLAT; rsp_valid rises in cycle t+READLAT+1.
- If rsp_ready is already high, the response lasts 1 cycle and the next command's strobe comes 2 cycles later.
- Full FIFO with a simultaneous pop: cmd_ready stays low that cycle. It rises the following cycle (registered full flag).
- Reset mid-operation: FIFO emptied, in-flight read discarded, pending response dropped, all outputs return to reset values on the next edge.

## Configuration
- LB_CMD_TIMESTAMP_EN defined: a 32-bit free-running cycle counter (reset 0, wraps) is added. Output rsp_ts[31:0] carries the counter value captured when lb_read was asserted.
- LB_CMD_TIMESTAMP_EN undefined: no counter and no rsp_ts port. All other behaviour is identical.

## Structure
- Package lb_cmd_pkg holds:
  - width localparams matching the defaults
  - the WRITECMD/READCMD codes
  - typedef struct lb_cmd_t {ctrl, addr, data}
  - typedef enum lb_seq_state_t {IDLE, ISSUE, RWAIT, RESP}
- Sub-module lb_cmd_fifo: synchronous FIFO of lb_cmd_t, FIFODEPTH deep, registered full/empty flags, same clk/reset.

## Test plan
- Single write ctrl=8'h01, addr=24'h000010, data=32'hDEADBEEF -> exactly one lb_wvalid cycle with those values, 2 cycles after push; no rsp_valid.
- Read addr=24'h000020, READLAT=4, lb_rdata model returns 32'h12345678 -> rsp_valid rises 5 cycles after lb_read with rsp_addr=24'h000020, rsp_data=32'h12345678.
- 20 writes pushed continuously -> cmd_ready low after 16 are buffered; all 20 strobes occur in order, 2 cycles apart; none dropped.
- Read followed by a write with rsp_ready held low for 10 cycles -> the write strobe occurs only after the rsp handshake; rsp_data stays stable throughout.
- ctrl=8'h55 then a write -> err_cnt=1, no strobe for 8'h55, the write issues normally.
- Reset asserted during RWAIT -> rsp_valid never asserts, busy=0, FIFO empty, a subsequent read completes correctly.
